// File: rtl/mbisr_pkg.sv
// Shared types and sizing for the built-in self-repair controller.
//   ADDR_W      address width of the 32-word test memory
//   NUM_SPARES  number of spare words / remap table entries
//   IDX_W       width of a spare index
//   state_t     sequencer states
//   remap_entry_t  one remap table entry (valid, addr)
package mbisr_pkg;

  localparam int ADDR_W     = 5;
  localparam int NUM_SPARES = 4;
  localparam int IDX_W      = $clog2(NUM_SPARES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT1,
    ST_VERIFY_START,
    ST_WAIT2,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } remap_entry_t;

endpackage

// File: rtl/mbisr_remap_cam.sv
// Spare-word remap table: NUM_SPARES entries with one write port, a bulk
// clear and two combinational query ports.
//   clk, rst        clock, synchronous active-high reset (clears table)
//   clr             clear all entries (new repair flow)
//   wr_en/wr_idx/wr_addr  write entry wr_idx with wr_addr, marking it valid
//   q0_addr/q0_hit  duplicate check for the failing address
//   q1_addr/q1_en   functional lookup; q1_hit/q1_idx gated by q1_en
module mbisr_remap_cam
  import mbisr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] q0_addr,
  output logic              q0_hit,
  input  logic [ADDR_W-1:0] q1_addr,
  input  logic              q1_en,
  output logic              q1_hit,
  output logic [IDX_W-1:0]  q1_idx
);

  remap_entry_t tbl_q [NUM_SPARES];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < NUM_SPARES; i++) tbl_q[i] <= '0;
    end else if (wr_en) begin
      tbl_q[wr_idx] <= '{valid: 1'b1, addr: wr_addr};
    end
  end

  // A write lands at the clock edge, so a strobe in the following cycle
  // already sees it in the registered table; no bypass path is needed.
  always_comb begin
    q0_hit = 1'b0;
    for (int i = 0; i < NUM_SPARES; i++) begin
      if (tbl_q[i].valid && tbl_q[i].addr == q0_addr) q0_hit = 1'b1;
    end
  end

  // Scan from the top down so the lowest matching index wins.
  logic             hit_raw;
  logic [IDX_W-1:0] idx_raw;

  always_comb begin
    hit_raw = 1'b0;
    idx_raw = '0;
    for (int i = NUM_SPARES - 1; i >= 0; i--) begin
      if (tbl_q[i].valid && tbl_q[i].addr == q1_addr) begin
        hit_raw = 1'b1;
        idx_raw = IDX_W'(i);
      end
    end
  end

  assign q1_hit = q1_en & hit_raw;
  assign q1_idx = (q1_en & hit_raw) ? idx_raw : '0;

endmodule

// File: rtl/mbisr_repair_ctrl.sv
// Built-in self-repair sequencer: runs an MBIST pass, logs failing
// addresses into the spare remap table, then runs a verify pass with the
// remap active and reports the outcome.
//   clk, rst            clock, synchronous active-high reset
//   start               begin a flow (accepted in IDLE or DONE only)
//   mbist_start         one-cycle pulse launching an MBIST pass
//   mbist_done          MBIST pass complete
//   mbist_fail_valid/mbist_fail_addr  failing-read strobe and address
//   func_addr           functional address to look up
//   remap_hit/remap_idx lookup result
//   remap_en            remap table active
//   done/fail/repaired/timeout  final status, held in DONE
//   spare_used          number of allocated spares
//
// state           | meaning
// ST_IDLE         | waiting for start
// ST_RUN          | pulse mbist_start for the test pass
// ST_WAIT1        | test pass running, logging failing addresses
// ST_VERIFY_START | pulse mbist_start for the verify pass
// ST_WAIT2        | verify pass running with remap active
// ST_DONE         | status held until next start
module mbisr_repair_ctrl
  import mbisr_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mbist_start,
  input  logic              mbist_done,
  input  logic              mbist_fail_valid,
  input  logic [ADDR_W-1:0] mbist_fail_addr,
  input  logic [ADDR_W-1:0] func_addr,
  output logic              remap_hit,
  output logic [IDX_W-1:0]  remap_idx,
  output logic              remap_en,
  output logic              done,
  output logic              fail,
  output logic              repaired,
  output logic              timeout,
  output logic [CNT_W-1:0]  spare_used
);

  localparam int WD_W = $clog2(TIMEOUT_CYC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] used_q, used_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             ov_q, ov_d;
  logic             vfail_q, vfail_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             tmo_q, tmo_d;
  logic             clr;
  logic             dup_hit;
  logic             room;
  logic             log_req;
  logic             wr_en;
  logic             ov_set;

  assign room    = used_q < CNT_W'(NUM_SPARES);
  assign log_req = (state_q == ST_WAIT1) && mbist_fail_valid && !dup_hit;
  assign wr_en   = log_req && room;
  assign ov_set  = log_req && !room;

  always_comb begin
    state_d     = state_q;
    used_d      = used_q;
    ov_d        = ov_q;
    vfail_d     = vfail_q;
    done_d      = done_q;
    fail_d      = fail_q;
    tmo_d       = tmo_q;
    wdog_d      = (wdog_q != '0) ? wdog_q - WD_W'(1) : wdog_q;
    clr         = 1'b0;
    mbist_start = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clr     = 1'b1;
          used_d  = '0;
          ov_d    = 1'b0;
          vfail_d = 1'b0;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_VERIFY_START: begin
        mbist_start = 1'b1;
        // Terminal count lands so that done rises TIMEOUT_CYC cycles
        // after the mbist_start pulse.
        wdog_d  = WD_W'(TIMEOUT_CYC - 2);
        state_d = (state_q == ST_RUN) ? ST_WAIT1 : ST_WAIT2;
      end
      ST_WAIT1: begin
        if (wr_en)  used_d = used_q + CNT_W'(1);
        if (ov_set) ov_d   = 1'b1;
        if (mbist_done) begin
          if (ov_q || ov_set) begin
            done_d  = 1'b1;
            fail_d  = 1'b1;
            state_d = ST_DONE;
          end else if (used_d == '0) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_VERIFY_START;
          end
        end else if (wdog_q == '0) begin
          done_d  = 1'b1;
          fail_d  = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT2: begin
        if (mbist_fail_valid) vfail_d = 1'b1;
        if (mbist_done) begin
          done_d  = 1'b1;
          fail_d  = vfail_q | mbist_fail_valid;
          state_d = ST_DONE;
        end else if (wdog_q == '0) begin
          done_d  = 1'b1;
          fail_d  = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      used_q  <= '0;
      wdog_q  <= '0;
      ov_q    <= 1'b0;
      vfail_q <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      used_q  <= used_d;
      wdog_q  <= wdog_d;
      ov_q    <= ov_d;
      vfail_q <= vfail_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
    end
  end

  assign remap_en   = (state_q == ST_VERIFY_START) || (state_q == ST_WAIT2) ||
                      ((state_q == ST_DONE) && !fail_q);
  assign done       = done_q;
  assign fail       = fail_q;
  assign timeout    = tmo_q;
  assign spare_used = used_q;
  assign repaired   = done_q && !fail_q && (used_q != '0);

  mbisr_remap_cam u_cam (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_idx  (used_q[IDX_W-1:0]),
    .wr_addr (mbist_fail_addr),
    .q0_addr (mbist_fail_addr),
    .q0_hit  (dup_hit),
    .q1_addr (func_addr),
    .q1_en   (remap_en),
    .q1_hit  (remap_hit),
    .q1_idx  (remap_idx)
  );

endmodule

// File: tb/tb_mbisr_repair_ctrl.sv
// Directed bench for mbisr_repair_ctrl.
module tb_mbisr_repair_ctrl;
  import mbisr_pkg::*;

  localparam int TO = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mbist_start;
  logic              mbist_done;
  logic              mbist_fail_valid;
  logic [ADDR_W-1:0] mbist_fail_addr;
  logic [ADDR_W-1:0] func_addr;
  logic              remap_hit;
  logic [IDX_W-1:0]  remap_idx;
  logic              remap_en;
  logic              done;
  logic              fail;
  logic              repaired;
  logic              timeout;
  logic [2:0]        spare_used;

  int checks   = 0;
  int failures = 0;

  int n_start    = 0;
  int cyc        = 0;
  int start_edge = 0;
  int done_edge  = 0;
  logic done_prev = 1'b0;

  mbisr_repair_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mbist_start      (mbist_start),
    .mbist_done       (mbist_done),
    .mbist_fail_valid (mbist_fail_valid),
    .mbist_fail_addr  (mbist_fail_addr),
    .func_addr        (func_addr),
    .remap_hit        (remap_hit),
    .remap_idx        (remap_idx),
    .remap_en         (remap_en),
    .done             (done),
    .fail             (fail),
    .repaired         (repaired),
    .timeout          (timeout),
    .spare_used       (spare_used)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    done_prev <= done;
    if (mbist_start) begin
      n_start    <= n_start + 1;
      start_edge <= cyc;
    end
    if (done && !done_prev) done_edge <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic strobe(input logic [ADDR_W-1:0] a);
    mbist_fail_valid = 1'b1;
    mbist_fail_addr  = a;
    tick();
    mbist_fail_valid = 1'b0;
  endtask

  task automatic pass_done();
    mbist_done = 1'b1;
    tick();
    mbist_done = 1'b0;
  endtask

  int base;
  int waited;

  initial begin
    rst              = 1'b1;
    start            = 1'b0;
    mbist_done       = 1'b0;
    mbist_fail_valid = 1'b0;
    mbist_fail_addr  = '0;
    func_addr        = '0;
    tick(3);

    // reset state
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_used", spare_used, 0);
    check("rst_remap_en", remap_en, 0);
    check("rst_mbist_start", mbist_start, 0);
    check("rst_no_pulses", n_start, 0);
    rst = 1'b0;
    tick();

    // 1: no faults
    base = n_start;
    do_start();
    check("t1_pulse", mbist_start, 1);
    tick(100);
    pass_done();
    check("t1_done", done, 1);
    check("t1_fail", fail, 0);
    check("t1_repaired", repaired, 0);
    check("t1_used", spare_used, 0);
    tick(3);
    check("t1_one_pulse", n_start - base, 1);

    // 2: faults 3 and 17 (17 twice), clean verify; start in WAIT1 ignored
    base = n_start;
    do_start();
    tick();
    strobe(5'd3);
    strobe(5'd17);
    strobe(5'd17);
    do_start();
    tick(2);
    check("t2_used", spare_used, 2);
    check("t2_done_low", done, 0);
    pass_done();
    check("t2_verify_pulse", mbist_start, 1);
    tick();
    func_addr = 5'd17;
    #1;
    check("t2_hit17", remap_hit, 1);
    check("t2_idx17", remap_idx, 1);
    func_addr = 5'd3;
    #1;
    check("t2_idx3", remap_idx, 0);
    tick(10);
    pass_done();
    check("t2_done", done, 1);
    check("t2_fail", fail, 0);
    check("t2_repaired", repaired, 1);
    check("t2_two_pulses", n_start - base, 2);
    func_addr = 5'd5;
    #1;
    check("t2_miss5", remap_hit, 0);

    // 3: overflow
    base = n_start;
    do_start();
    tick();
    strobe(5'd0);
    strobe(5'd5);
    strobe(5'd9);
    strobe(5'd12);
    strobe(5'd30);
    pass_done();
    check("t3_done", done, 1);
    check("t3_fail", fail, 1);
    check("t3_used", spare_used, 4);
    check("t3_remap_en", remap_en, 0);
    check("t3_timeout", timeout, 0);
    func_addr = 5'd0;
    #1;
    check("t3_no_hit", remap_hit, 0);
    tick(5);
    check("t3_one_pulse", n_start - base, 1);

    // 4: verify failure on repaired address
    do_start();
    tick();
    strobe(5'd9);
    pass_done();
    tick();
    strobe(5'd9);
    tick(2);
    pass_done();
    check("t4_done", done, 1);
    check("t4_fail", fail, 1);
    check("t4_repaired", repaired, 0);
    check("t4_used", spare_used, 1);

    // 5: watchdog
    do_start();
    waited = 0;
    while (!done && waited < TO + 100) begin
      tick();
      waited++;
    end
    tick();
    check("t5_done", done, 1);
    check("t5_fail", fail, 1);
    check("t5_timeout", timeout, 1);
    check("t5_latency", done_edge - start_edge, TO);

    // 6: reset in WAIT2
    do_start();
    tick();
    strobe(5'd9);
    pass_done();
    tick(3);
    func_addr = 5'd9;
    #1;
    check("t6_pre_hit", remap_hit, 1);
    base = n_start;
    rst = 1'b1;
    tick();
    check("t6_done", done, 0);
    check("t6_used", spare_used, 0);
    check("t6_remap_en", remap_en, 0);
    check("t6_hit", remap_hit, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    check("t6_no_pulse", n_start - base, 0);
    do_start();
    check("t6_restart_pulse", mbist_start, 1);
    tick(4);
    pass_done();
    check("t6_restart_done", done, 1);
    check("t6_restart_fail", fail, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mbisr_repair_ctrl.md
Name: mbisr_repair_ctrl

Overview:
Sequencer for the built-in self-repair flow around the 32-word test memory and its MBIST engine. On start it launches an MBIST pass, logs each failing address into a small spare-word remap table, then launches a second verify pass with the remap active. It reports done/fail/repaired status. The memory wrapper uses its combinational remap lookup to steer accesses to spare words.

Parameters:
ADDR_W, 5, memory address width (32 words)
NUM_SPARES, 4, number of spare words / remap table entries
TIMEOUT_CYC, 4096, max cycles per MBIST pass before a forced fail
CNT_W, 3, width of spare_used; must satisfy 2**CNT_W > NUM_SPARES

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins the repair flow when in IDLE or DONE
mbist_start  out  1  one-cycle pulse launching an MBIST pass
mbist_done  in  1  MBIST pass complete (level or pulse; first high cycle counts)
mbist_fail_valid  in  1  one-cycle strobe per failing read
mbist_fail_addr  in  ADDR_W  failing address, valid with strobe
func_addr  in  ADDR_W  address to look up in remap table
remap_hit  out  1  func_addr matches a valid entry and remap_en=1 (combinational)
remap_idx  out  clog2(NUM_SPARES)  spare index for the hit; 0 when no hit
remap_en  out  1  remap table active (VERIFY state, and DONE with fail=0)
done  out  1  flow finished; held until next accepted start or rst
fail  out  1  unrepairable: overflow, verify failure, or timeout
repaired  out  1  done=1, fail=0, spare_used>0
timeout  out  1  a pass exceeded TIMEOUT_CYC
spare_used  out  CNT_W  number of allocated spares

Behaviour:
- Reset: all outputs 0, table valid bits cleared, spare_used=0, state IDLE. Reset mid-flow aborts immediately; no mbist_start is issued during or after reset.
- States: IDLE, RUN, WAIT1, VERIFY_START, WAIT2, DONE.
- IDLE/DONE + start (cycle N): clear table, counters and flags; mbist_start=1 in cycle N+1 (RUN); WAIT1 from N+2. start is ignored in every other state.
- WAIT1 + mbist_fail_valid: if the address equals a valid entry, ignore it. Else if spare_used<NUM_SPARES, write entry[spare_used] and increment spare_used (visible the next cycle). Else set overflow.
- Back-to-back duplicate strobes must be deduplicated. Compare against the registered table plus the entry being written this cycle.
- WAIT1 + mbist_done (cycle M):
  - overflow → DONE, fail=1.
  - spare_used==0 → DONE, fail=0.
  - otherwise → VERIFY_START, which pulses mbist_start at M+1; WAIT2 from M+2.
- A fail strobe in the same cycle as mbist_done is logged before the decision.
- WAIT2 + mbist_fail_valid: set verify_fail. The table is frozen.
- WAIT2 + mbist_done → DONE, fail=verify_fail.
- done, fail, repaired and timeout become valid the cycle after the deciding input and are held in DONE.
- Watchdog: the per-pass counter resets on each mbist_start. Reaching TIMEOUT_CYC in WAIT1 or WAIT2 → DONE with fail=1, timeout=1.
- mbist_done and fail strobes in IDLE, RUN, VERIFY_START or DONE are ignored.
- Lookup: purely combinational on func_addr. When several entries match, the lowest index wins (cannot occur by construction).

Decomposition:
- Package mbisr_pkg: state enum, ADDR_W/NUM_SPARES defaults, remap entry struct (valid, addr).
- One sub-module, mbisr_remap_cam: NUM_SPARES registers with write port, clear, and combinational match/encode for two query ports (fail_addr dedup, func_addr lookup).

Test Plan:
- No faults: start, mbist_done 100 cycles later, no strobes → exactly one mbist_start; done=1, fail=0, repaired=0, spare_used=0.
- Faults at 3 and 17 (17 strobed twice back-to-back), clean verify → spare_used=2, second mbist_start pulse, func_addr=17 → remap_hit=1, remap_idx=1; done=1, fail=0, repaired=1.
- Five distinct faults (0, 5, 9, 12, 30) → spare_used=4, overflow; done=1, fail=1 after pass 1; no second mbist_start; remap_en=0.
- Pass 1 logs addr 9, pass 2 strobes addr 9 → done=1, fail=1, repaired=0.
- mbist_done never asserted → done=1, fail=1, timeout=1 exactly TIMEOUT_CYC cycles after the mbist_start pulse.
- rst asserted in WAIT2 → next cycle all outputs 0, table empty, remap_hit=0 for a previously logged address. A new start runs normally.
